// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART register-bus arbiter.
// The UART_ARB_RR_EN build option is consumed by uart_arb_pick and uart_bus_arbiter.
package uart_arb_pkg;

    localparam int NUM_PORTS  = 2;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } state_t;

    function automatic logic [NUM_PORTS-1:0] portOneHot(input logic port);
        portOneHot = port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/uart_arb_pick.sv
// Combinational winner selection between the two requesters.
// UART_ARB_RR_EN defined: round-robin on ties; undefined: port 0 has fixed priority.
module uart_arb_pick
    import uart_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
`ifdef UART_ARB_RR_EN
    input  logic                 lastGrant,
`endif
    output logic                 grantPort,
    output logic                 grantValid
);

    always_comb begin
        grantValid = |req;
`ifdef UART_ARB_RR_EN
        if (&req)
            grantPort = ~lastGrant;
        else
            grantPort = req[1];
`else
        grantPort = ~req[0];
`endif
    end

endmodule

// File: rtl/uart_bus_arbiter.sv
// Two-port arbiter and setup/strobe/hold cycle sequencer for the UART core register bus.
// Build option UART_ARB_RR_EN selects round-robin arbitration instead of fixed priority.
module uart_bus_arbiter
    import uart_arb_pkg::*;
#(
    parameter int STROBE_CYCLES = 2,
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int DATA_W        = DEF_DATA_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] p_Req_i,
    input  logic [NUM_PORTS-1:0] p_We_i,
    input  logic [ADDR_W-1:0]    Addr0_i,
    input  logic [ADDR_W-1:0]    Addr1_i,
    input  logic [DATA_W-1:0]    WData0_i,
    input  logic [DATA_W-1:0]    WData1_i,
    output logic [NUM_PORTS-1:0] p_Ack_o,
    output logic [DATA_W-1:0]    RData_o,
    output logic                 p_Busy_o,
    output logic [ADDR_W-1:0]    AddrBus_o,
    output logic                 n_ChipSelect_o,
    output logic                 n_rd_o,
    output logic                 n_we_o,
    output logic [DATA_W-1:0]    DataBus_o,
    input  logic [DATA_W-1:0]    DataBus_i
);

    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);

    state_t               state, nextState;
    logic [3:0]           strobeCnt;
    logic                 curPort, curWe;
    logic                 pickPort, pickValid, grantNow;
    logic                 nCsNext, nRdNext, nWeNext, busyNext;
    logic [NUM_PORTS-1:0] ackNext;
    logic [ADDR_W-1:0]    addrNext;
    logic [DATA_W-1:0]    dataNext, rDataNext;

`ifdef UART_ARB_RR_EN
    logic lastGrant;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            lastGrant <= 1'b1;
        else if (grantNow)
            lastGrant <= pickPort;
    end

    uart_arb_pick uPick (
        .req        (p_Req_i),
        .lastGrant  (lastGrant),
        .grantPort  (pickPort),
        .grantValid (pickValid)
    );
`else
    uart_arb_pick uPick (
        .req        (p_Req_i),
        .grantPort  (pickPort),
        .grantValid (pickValid)
    );
`endif

    assign grantNow = (state == ST_IDLE) && pickValid;

    // Outputs are registered from next-state values so the pins line up with the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            strobeCnt      <= 4'd0;
            curPort        <= 1'b0;
            curWe          <= 1'b0;
            n_ChipSelect_o <= 1'b1;
            n_rd_o         <= 1'b1;
            n_we_o         <= 1'b1;
            p_Busy_o       <= 1'b0;
            p_Ack_o        <= '0;
            AddrBus_o      <= '0;
            DataBus_o      <= '0;
            RData_o        <= '0;
        end else begin
            state <= nextState;
            if (state == ST_SETUP)
                strobeCnt <= STROBE_LOAD;
            else if (state == ST_STROBE && strobeCnt != 4'd0)
                strobeCnt <= strobeCnt - 4'd1;
            if (grantNow) begin
                curPort <= pickPort;
                curWe   <= p_We_i[pickPort];
            end
            n_ChipSelect_o <= nCsNext;
            n_rd_o         <= nRdNext;
            n_we_o         <= nWeNext;
            p_Busy_o       <= busyNext;
            p_Ack_o        <= ackNext;
            AddrBus_o      <= addrNext;
            DataBus_o      <= dataNext;
            RData_o        <= rDataNext;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE:   if (pickValid) nextState = ST_SETUP;
            ST_SETUP:  nextState = ST_STROBE;
            ST_STROBE: if (strobeCnt == 4'd0) nextState = ST_HOLD;
            ST_HOLD:   nextState = ST_IDLE;
            default:   nextState = ST_IDLE;
        endcase
    end

    always_comb begin
        nCsNext   = (nextState == ST_IDLE);
        nRdNext   = !((nextState == ST_STROBE) && !curWe);
        nWeNext   = !((nextState == ST_STROBE) && curWe);
        busyNext  = (nextState != ST_IDLE);
        ackNext   = (nextState == ST_HOLD) ? portOneHot(curPort) : '0;
        addrNext  = AddrBus_o;
        dataNext  = DataBus_o;
        rDataNext = RData_o;
        if (grantNow) begin
            addrNext = pickPort ? Addr1_i : Addr0_i;
            dataNext = pickPort ? WData1_i : WData0_i;
        end
        // Read data is taken on the edge that leaves STROBE.
        if (state == ST_STROBE && nextState == ST_HOLD && !curWe)
            rDataNext = DataBus_i;
    end

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Self-checking bench for uart_bus_arbiter: vector table, scoreboard on acks, corner sequences.
module tb_uart_bus_arbiter;

    localparam int S  = 2;
    localparam int AW = 4;
    localparam int DW = 8;
`ifdef UART_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [1:0]    req = 2'b00, we = 2'b00, reqS1 = 2'b00, reqS15 = 2'b00;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0, coreRd = '0;

    logic [1:0]    ack, ackS1, ackS15;
    logic [DW-1:0] rData, rDataS1, rDataS15, dataBus, dataS1, dataS15;
    logic [AW-1:0] addrBus, addrS1, addrS15;
    logic          busy, nCs, nRd, nWe;
    logic          busyS1, nCsS1, nRdS1, nWeS1;
    logic          busyS15, nCsS15, nRdS15, nWeS15;

    always #5 clk = ~clk;

    uart_bus_arbiter #(.STROBE_CYCLES(S), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .p_Req_i(req), .p_We_i(we),
        .Addr0_i(addr0), .Addr1_i(addr1), .WData0_i(wdata0), .WData1_i(wdata1),
        .p_Ack_o(ack), .RData_o(rData), .p_Busy_o(busy), .AddrBus_o(addrBus),
        .n_ChipSelect_o(nCs), .n_rd_o(nRd), .n_we_o(nWe),
        .DataBus_o(dataBus), .DataBus_i(coreRd)
    );

    uart_bus_arbiter #(.STROBE_CYCLES(1), .ADDR_W(AW), .DATA_W(DW)) dutS1 (
        .clk(clk), .rst(rst), .p_Req_i(reqS1), .p_We_i(we),
        .Addr0_i(addr0), .Addr1_i(addr1), .WData0_i(wdata0), .WData1_i(wdata1),
        .p_Ack_o(ackS1), .RData_o(rDataS1), .p_Busy_o(busyS1), .AddrBus_o(addrS1),
        .n_ChipSelect_o(nCsS1), .n_rd_o(nRdS1), .n_we_o(nWeS1),
        .DataBus_o(dataS1), .DataBus_i(coreRd)
    );

    uart_bus_arbiter #(.STROBE_CYCLES(15), .ADDR_W(AW), .DATA_W(DW)) dutS15 (
        .clk(clk), .rst(rst), .p_Req_i(reqS15), .p_We_i(we),
        .Addr0_i(addr0), .Addr1_i(addr1), .WData0_i(wdata0), .WData1_i(wdata1),
        .p_Ack_o(ackS15), .RData_o(rDataS15), .p_Busy_o(busyS15), .AddrBus_o(addrS15),
        .n_ChipSelect_o(nCsS15), .n_rd_o(nRdS15), .n_we_o(nWeS15),
        .DataBus_o(dataS15), .DataBus_i(coreRd)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]    ack;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          isWr;
    } exp_t;

    typedef struct {
        logic          port;
        logic          isWr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            ackCyc;
        int            weLow;
        int            rdLow;
    } vec_t;

    exp_t sbQ[$];
    exp_t sbExp;
    logic overlap = 1'b0;

    // Scoreboard: every ack from the main DUT pops one expected transaction.
    always @(negedge clk) begin
        if (!nRd && !nWe) overlap = 1'b1;
        if (rst && ack != 2'b00) begin
            if (sbQ.size() == 0) begin
                check("unexpected ack", 32'(ack), 32'h0);
            end else begin
                sbExp = sbQ.pop_front();
                check("ack port", 32'(ack), 32'(sbExp.ack));
                check("bus addr in hold", 32'(addrBus), 32'(sbExp.addr));
                if (sbExp.isWr)
                    check("bus write data", 32'(dataBus), 32'(sbExp.data));
                else
                    check("read data", 32'(rData), 32'(sbExp.data));
                check("strobe overlap", 32'(overlap), 32'h0);
            end
        end
    end

    function automatic exp_t mkExp(input logic port, input logic isWr,
                                   input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        e.ack  = port ? 2'b10 : 2'b01;
        e.addr = a;
        e.data = d;
        e.isWr = isWr;
        return e;
    endfunction

    task automatic setPort(input logic port, input logic isWr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (port) begin
            addr1  = a;
            wdata1 = d;
        end else begin
            addr0  = a;
            wdata0 = d;
        end
        we[port] = isWr;
    endtask

    task automatic runVec(input vec_t v);
        int ackAt = 0, weLow = 0, rdLow = 0, csLow = 0, busyHi = 0;
        sbQ.push_back(mkExp(v.port, v.isWr, v.addr, v.data));
        setPort(v.port, v.isWr, v.addr, v.isWr ? v.data : 8'h99);
        coreRd = v.isWr ? 8'hEE : v.data;
        req[v.port] = 1'b1;
        for (int k = 1; k <= 40 && ackAt == 0; k++) begin
            @(negedge clk);
            weLow  += int'(!nWe);
            rdLow  += int'(!nRd);
            csLow  += int'(!nCs);
            busyHi += int'(busy);
            if (ack != 2'b00) begin
                ackAt = k;
                req[v.port] = 1'b0;
            end
        end
        check("ack cycle", ackAt, v.ackCyc);
        check("n_we low cycles", weLow, v.weLow);
        check("n_rd low cycles", rdLow, v.rdLow);
        check("chip select low cycles", csLow, v.ackCyc);
        check("busy cycles", busyHi, v.ackCyc);
        @(negedge clk);
        check("idle chip select", 32'(nCs), 32'h1);
        check("idle busy", 32'(busy), 32'h0);
    endtask

    vec_t vecs[6];

    initial begin
        int acks, grantIdx, ack0At, ack1At, csAt5, lowCnt, ackAt;
        logic [1:0] gotGrants [4];

        vecs[0] = '{1'b0, 1'b1, 4'h3, 8'hA5, 4, 2, 0};
        vecs[1] = '{1'b1, 1'b0, 4'h0, 8'h5C, 4, 0, 2};
        vecs[2] = '{1'b0, 1'b0, 4'hF, 8'h81, 4, 0, 2};
        vecs[3] = '{1'b1, 1'b1, 4'h7, 8'h3C, 4, 2, 0};
        vecs[4] = '{1'b0, 1'b1, 4'h0, 8'hFF, 4, 2, 0};
        vecs[5] = '{1'b1, 1'b0, 4'hA, 8'h00, 4, 0, 2};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset strobes/cs", 32'({nCs, nRd, nWe}), 32'h7);
        check("reset ack/busy", 32'({ack, busy}), 32'h0);
        check("reset buses", 32'({addrBus, dataBus, rData}), 32'h0);
        rst = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) runVec(vecs[i]);

        // Both ports requesting continuously
        setPort(1'b0, 1'b1, 4'h1, 8'h11);
        setPort(1'b1, 1'b1, 4'h2, 8'h22);
        for (int i = 0; i < 4; i++) begin
            if (RR && (i % 2 == 1))
                sbQ.push_back(mkExp(1'b1, 1'b1, 4'h2, 8'h22));
            else
                sbQ.push_back(mkExp(1'b0, 1'b1, 4'h1, 8'h11));
        end
        req = 2'b11;
        acks = 0;
        for (int k = 0; k < 60 && acks < 4; k++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                gotGrants[acks] = ack;
                acks++;
                if (acks == 4) req = 2'b00;
            end
        end
        check("contention grant count", acks, 4);
        for (grantIdx = 0; grantIdx < 4 && grantIdx < acks; grantIdx++)
            check("contention grant order", 32'(gotGrants[grantIdx]),
                  (RR && grantIdx % 2 == 1) ? 32'h2 : 32'h1);
        @(negedge clk);

        // Port 1 arrives during port 0's strobe
        setPort(1'b0, 1'b1, 4'h4, 8'h44);
        setPort(1'b1, 1'b0, 4'h5, 8'h99);
        coreRd = 8'h5A;
        sbQ.push_back(mkExp(1'b0, 1'b1, 4'h4, 8'h44));
        sbQ.push_back(mkExp(1'b1, 1'b0, 4'h5, 8'h5A));
        req = 2'b01;
        ack0At = 0; ack1At = 0; csAt5 = 0;
        for (int k = 1; k <= 30 && ack1At == 0; k++) begin
            @(negedge clk);
            if (k == 2) req[1] = 1'b1;
            if (k == 5) csAt5 = int'(nCs);
            if (ack[0]) begin ack0At = k; req[0] = 1'b0; end
            if (ack[1]) begin ack1At = k; req[1] = 1'b0; end
        end
        check("late arrival port0 ack", ack0At, 4);
        check("late arrival port1 ack", ack1At, 9);
        check("chip select gap", csAt5, 1);
        @(negedge clk);

        // Reset asserted in the middle of a strobe
        setPort(1'b0, 1'b1, 4'h6, 8'h66);
        req = 2'b01;
        repeat (2) @(negedge clk);
        check("in strobe before reset", 32'(nWe), 32'h0);
        rst = 1'b0;
        req = 2'b00;
        #1;
        check("async reset strobes/cs", 32'({nCs, nRd, nWe}), 32'h7);
        check("async reset ack/busy", 32'({ack, busy}), 32'h0);
        check("async reset addr", 32'(addrBus), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        runVec('{1'b1, 1'b1, 4'h9, 8'h99, 4, 2, 0});

        // STROBE_CYCLES = 1, port 0 write
        setPort(1'b0, 1'b1, 4'hC, 8'hC1);
        reqS1 = 2'b01;
        lowCnt = 0; ackAt = 0;
        for (int k = 1; k <= 40 && ackAt == 0; k++) begin
            @(negedge clk);
            lowCnt += int'(!nWeS1);
            if (ackS1 != 2'b00) begin
                ackAt = k;
                reqS1 = 2'b00;
                check("S1 ack port", 32'(ackS1), 32'h1);
                check("S1 addr/data", 32'({addrS1, dataS1}), 32'hCC1);
                check("S1 busy in hold", 32'(busyS1), 32'h1);
            end
            if (!nRdS1) check("S1 n_rd stays high", 32'(nRdS1), 32'h1);
        end
        check("S1 strobe width", lowCnt, 1);
        check("S1 ack cycle", ackAt, 3);
        check("S1 read data untouched", 32'(rDataS1), 32'h0);
        @(negedge clk);
        check("S1 idle cs", 32'(nCsS1), 32'h1);

        // STROBE_CYCLES = 15, port 1 read
        setPort(1'b1, 1'b0, 4'hD, 8'h99);
        coreRd = 8'hD5;
        reqS15 = 2'b10;
        lowCnt = 0; ackAt = 0;
        for (int k = 1; k <= 40 && ackAt == 0; k++) begin
            @(negedge clk);
            lowCnt += int'(!nRdS15);
            if (!nWeS15) check("S15 n_we stays high", 32'(nWeS15), 32'h1);
            if (ackS15 != 2'b00) begin
                ackAt = k;
                reqS15 = 2'b00;
                check("S15 ack port", 32'(ackS15), 32'h2);
                check("S15 read data", 32'(rDataS15), 32'hD5);
                check("S15 addr/data", 32'({addrS15, dataS15}), 32'hD99);
                check("S15 busy/cs in hold", 32'({busyS15, nCsS15}), 32'h2);
            end
        end
        check("S15 strobe width", lowCnt, 15);
        check("S15 ack cycle", ackAt, 17);

        repeat (4) @(negedge clk);
        check("scoreboard drained", sbQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_bus_arbiter.md
# uart_bus_arbiter

Two-port bus arbiter and cycle sequencer in front of the UART core's register bus (address, chip select, read and write strobes, and data). It accepts single-byte register read and write requests from two independent requesters, for example a host CPU and a frame scheduler. It grants one request at a time and generates a correctly phased bus cycle: chip select and address set up first, then a strobe of programmable width, then a hold phase. Read data and a one-cycle acknowledge go back to the granted requester.

## Interface
- STROBE_CYCLES, 2: width of the n_rd/n_we low pulse, in clk cycles; legal range 1..15.
- ADDR_W, 4: register address width.
- DATA_W, 8: data width.
- clk  in  1  system clock (40 MHz)
- rst  in  1  reset; one clock domain, reset asynchronous and active-low.
- p_Req_i  in  2  per-port request; bit n belongs to port n.
- p_We_i  in  2  per-port direction; 1 = write, 0 = read.
- Addr0_i / Addr1_i  in  ADDR_W  per-port register address.
- WData0_i / WData1_i  in  DATA_W  per-port write data.
- p_Ack_o  out  2  one-cycle completion pulse per port.
- RData_o  out  DATA_W  captured read data; valid when any p_Ack_o bit is high.
- p_Busy_o  out  1  high while a bus cycle is in progress.
- AddrBus_o  out  ADDR_W  to core AddrBus_i.
- n_ChipSelect_o  out  1  to core n_ChipSelect_i.
- n_rd_o / n_we_o  out  1  to core strobes.
- DataBus_o  out  DATA_W  to core DataBus_i.
- DataBus_i  in  DATA_W  from core DataBus_o.

## Operation
- FSM states and transitions:
  - IDLE: if any p_Req_i bit is set, pick the winner, latch its address, direction and write data, then go to SETUP.
  - SETUP: one cycle; go to STROBE.
  - STROBE: count STROBE_CYCLES cycles, then go to HOLD.
  - HOLD: one cycle; go to IDLE.
- Bus pin behaviour per state:
  - SETUP: n_ChipSelect_o=0, AddrBus_o and DataBus_o driven, both strobes high.
  - STROBE: n_ChipSelect_o=0; n_we_o=0 for a write, n_rd_o=0 for a read.
  - HOLD: n_ChipSelect_o=0, strobes high, address and data held.
  - IDLE: n_ChipSelect_o=1; AddrBus_o and DataBus_o keep their last values.
- n_rd_o and n_we_o are never low in the same cycle.
- A read captures DataBus_i on the clock edge that leaves STROBE.
- The requester must hold its request fields stable from raising p_Req_i until it sees p_Ack_o.
- Once latched, a transaction always completes. Dropping p_Req_i mid-cycle does not abort it, and its ack still pulses.
- A request still high in the IDLE cycle after its ack is treated as a new transaction.
- Arbitration happens only in IDLE. Requests arriving mid-cycle wait.
- The last_grant register updates on every grant.
- All outputs are registered.

## Timing
- Reset values:
  - n_ChipSelect_o=1, n_rd_o=1, n_we_o=1.
  - AddrBus_o=0, DataBus_o=0, RData_o=0.
  - p_Ack_o=0, p_Busy_o=0.
  - State = IDLE; last_grant=1, so port 0 wins the first tie.
- Cycle by cycle, with the request sampled in IDLE at cycle 0:
  - cycle 1: SETUP.
  - cycles 2..1+S: STROBE, where S = STROBE_CYCLES.
  - cycle 2+S: HOLD, with p_Ack_o and RData_o valid.
  - cycle 3+S: IDLE again.
- Throughput is one transaction per S+3 cycles.
- p_Busy_o is high in SETUP, STROBE and HOLD.
- The strobe counter is 4 bits wide, counts down from S-1 to 0, and is loaded on entry to STROBE.
- Reset asserted mid-cycle immediately forces all outputs to their reset values. The in-flight transaction gets no ack.

## Configuration
- UART_ARB_RR_EN defined: round-robin arbitration. On a tie, the port other than last_grant wins.
- UART_ARB_RR_EN undefined: fixed priority, port 0 always wins. last_grant is not implemented.

## Structure
- Package uart_arb_pkg holds:
  - the state enum (ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD);
  - the ADDR_W and DATA_W defaults;
  - the port-count constant NUM_PORTS = 2.
- One sub-module, uart_arb_pick: combinational winner selection from p_Req_i and last_grant, wrapping the UART_ARB_RR_EN choice.

## Test plan
- Port 0 writes addr 0x3, data 0xA5, with S=2 → n_we_o low for cycles 2–3, n_ChipSelect_o low for cycles 1–4, p_Ack_o=01 at cycle 4, AddrBus_o=0x3, DataBus_o=0xA5.
- Port 1 reads addr 0x0 while the core model drives 0x5C → n_rd_o low for S cycles, RData_o=0x5C with p_Ack_o=10; n_we_o never low.
- Both ports hold requests continuously with UART_ARB_RR_EN defined → grants alternate 0,1,0,1. Without the macro → port 0 gets every grant while it keeps requesting.
- Port 1 raises p_Req_i during port 0's STROBE → port 1 is granted in the IDLE after port 0's HOLD; no overlap of chip-select cycles.
- rst asserted during STROBE → strobes and chip select go high asynchronously, no ack. After release, a new request completes normally.
- STROBE_CYCLES=1 and 15 → strobe low for exactly 1 and 15 cycles; ack at cycle 3 and cycle 17 respectively.
